clk_div_n: RTL and testbench
============================

Name: clk_div_n

Overview:
Programmable integer clock divider, single clk_in domain, generalising the fixed divide-by-4 divider to any ratio N in 2..2^DIV_W-1.
- Runtime divisor load with handshake, applied only at period boundaries, so there are no runt pulses.
- Glitch-free start/stop via enable.
- One-cycle rise strobe for downstream logic that stays on clk_in.

Parameters:
DIV_W, 8, width of divisor and internal counter.
DIV_RESET, 4, divisor in effect after reset; must be >= 2.

Ports:
clk_in  input  1  source clock; all logic on posedge clk_in except the optional negedge flop.
reset  input  1  asynchronous, active-high reset.
enable  input  1  run request; level sensitive.
div_val  input  DIV_W  requested divisor N.
div_load  input  1  one-cycle strobe; captures div_val.
div_ack  output  1  one-cycle pulse when a loaded divisor takes effect.
div_err  output  1  one-cycle pulse when div_load carries div_val < 2.
busy  output  1  high while a loaded divisor is pending.
clk_out  output  1  divided clock, registered.
rise_stb  output  1  high for the clk_in cycle in which clk_out first reads 1 in each period.

Behaviour:
- Reset, asynchronous, any state:
  - state=IDLE, cnt=0, divisor=DIV_RESET, pending cleared.
  - clk_out=0, rise_stb=0, div_ack=0, div_err=0, busy=0.
- States:
  - IDLE: clk_out=0, cnt held at 0.
  - RUN: free-running division.
  - STOP: finishing the current period before returning to IDLE.
- IDLE->RUN when enable=1. On that edge: cnt<=0, clk_out<=1, rise_stb<=1. Latency from enable sampled high to clk_out=1 is 1 cycle.
- RUN counting:
  - cnt increments by 1 each cycle and wraps N-1->0.
  - clk_out=1 while cnt < floor(N/2), else 0.
  - Result: high floor(N/2) cycles, low ceil(N/2) cycles, period exactly N.
- RUN->STOP when enable=0 is sampled.
  - STOP continues counting until the wrap at cnt=N-1, then enters IDLE with clk_out=0.
  - Every started period completes in full.
  - enable re-asserted during STOP returns to RUN with no gap.
- Divisor load:
  - div_load with div_val>=2 stores the value as pending; busy=1 the next cycle.
  - In IDLE, pending is applied the next cycle.
  - In RUN/STOP, pending is applied on the wrap edge (cnt N-1->0). The new N governs the period starting at that edge.
  - div_ack pulses on the apply edge; busy drops on the same edge.
  - A second div_load while pending overwrites it (last wins). Only one div_ack is issued.
  - div_load on the wrap edge itself: the old pending value (if any) is applied. The new value becomes pending and applies at the next wrap.
  - div_val 0 or 1: div_err pulses next cycle; divisor and pending are unchanged.
- Counter width: DIV_W bits. Comparisons are unsigned. N=2^DIV_W-1 is legal.
- rise_stb = registered (next cnt==0 and entering/staying in RUN/STOP). It is never asserted in IDLE.

Optional Feature:
Macro CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - Adds one negedge clk_in flop that samples the posedge clk_out term.
  - For odd N, clk_out = OR of posedge and negedge terms, giving high time N/2 clk_in periods (exact 50% duty). Effective falling edge is half a cycle later.
  - Even N is unaffected, and reset also clears the negedge flop asynchronously.
- Undefined: no negedge logic; duty is floor(N/2)/N as above.

Test Plan:
1. Reset release with enable=1, no load. Expect: clk_out period 4, high 2 / low 2; first clk_out=1 one cycle after enable sampled; rise_stb every 4 cycles.
2. Load div_val=7 mid-period (cnt=1). Expect: current period finishes at 4; div_ack on wrap; next periods are 7 with high 3 / low 4 (macro defined: high 3.5 cycles).
3. Two loads, 5 then 9, one cycle apart, before the wrap. Expect: single div_ack; period becomes 9; busy high from the first load until the apply edge.
4. div_load with div_val=1 and with 0. Expect: div_err pulse each time; period unchanged; no div_ack; busy stays 0.
5. enable dropped at cnt=1 with N=6. Expect: clk_out completes its 6-cycle period, then stays 0 in IDLE; re-enable restarts with clk_out=1 after 1 cycle.
6. reset pulsed during RUN with N=9 and a pending load. Expect: immediate clk_out=0 and busy=0; after release the divisor is 4, with no div_ack.

Source files
------------

// File: rtl/clk_div_n.sv
// clk_div_n: programmable integer clock divider with glitch-free start/stop.
// Optional macro CLK_DIV_ODD_DUTY50_EN: negedge stretch for 50% duty on odd N.
module clk_div_n #(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic             clk_out,
    output logic             rise_stb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             wrap;
    logic             running;
    logic             apply;
    logic             load_ok;
    logic             load_bad;
    logic             active_d;
    logic [DIV_W-1:0] half_d;

    // Next-state, divisor pipeline and registered output terms
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        wrap     = (cnt_q == (div_q - DIV_W'(1)));
        running  = (state_q != IDLE);
        apply    = pend_vld_q && (!running || wrap);
        load_ok  = div_load && (div_val >= DIV_W'(2));
        load_bad = div_load && (div_val < DIV_W'(2));

        // A pending divisor only takes over at a period boundary
        if (apply) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end

        // A load on the apply edge becomes the next pending value
        if (load_ok) begin
            pend_d     = div_val;
            pend_vld_d = 1'b1;
        end
        err_d = load_bad;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN, STOP: begin
                if (wrap) begin
                    cnt_d   = '0;
                    state_d = enable ? RUN : IDLE;
                end else begin
                    cnt_d   = cnt_q + DIV_W'(1);
                    state_d = enable ? RUN : STOP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        active_d = (state_d != IDLE);
        half_d   = div_d >> 1;
        clk_d    = active_d && (cnt_d < half_d);
        rise_d   = active_d && (cnt_d == '0);
    end

    // State, counter, divisor and output registers
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_W'(DIV_RESET);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign div_ack  = ack_q;
    assign div_err  = err_q;
    assign busy     = pend_vld_q;
    assign rise_stb = rise_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic neg_q, neg_d;

    // Stretch the high phase by half a cycle when the period is odd
    always_comb begin
        neg_d = clk_q & div_q[0];
    end

    // Negedge copy of the posedge term
    always_ff @(negedge clk_in or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign clk_out = clk_q | neg_q;
`else
    assign clk_out = clk_q;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// tb_clk_div_n: directed scenarios plus random traffic against a
// period-level reference model of the divider.
module tb_clk_div_n;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         div_load = 1'b0;
    logic         div_ack;
    logic         div_err;
    logic         busy;
    logic         clk_out;
    logic         rise_stb;

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    clk_div_n #(.DIV_W(W), .DIV_RESET(4)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (enable),
        .div_val  (div_val),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .busy     (busy),
        .clk_out  (clk_out),
        .rise_stb (rise_stb)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a period is "active" with phase m_ph and length m_n.
    // Only the enable level at the end of a period decides whether
    // another period follows.
    bit m_act;
    int m_ph;
    int m_n;
    int m_pend;
    bit m_clk, m_vis, m_rise, m_ack, m_err;

    always @(posedge clk_in) begin
        bit endp, apply, prev;
        int nn;
        if (reset) begin
            m_act  = 1'b0;
            m_ph   = 0;
            m_n    = 4;
            m_pend = -1;
            m_clk  = 1'b0;
            m_vis  = 1'b0;
            m_rise = 1'b0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
        end else begin
            endp  = m_act && (m_ph == m_n - 1);
            apply = (m_pend >= 0) && (!m_act || endp);
            nn    = apply ? m_pend : m_n;
            if (apply) m_pend = -1;
            m_err = 1'b0;
            if (div_load) begin
                if (div_val < 2) m_err = 1'b1;
                else m_pend = int'(div_val);
            end
            if (!m_act) begin
                if (enable) begin
                    m_act = 1'b1;
                    m_ph  = 0;
                end
            end else if (endp) begin
                if (enable) m_ph = 0;
                else m_act = 1'b0;
            end else begin
                m_ph++;
            end
            prev   = m_clk && (m_n % 2 == 1);
            m_n    = nn;
            m_clk  = m_act && (m_ph < m_n / 2);
            m_rise = m_act && (m_ph == 0);
            m_ack  = apply;
`ifdef CLK_DIV_ODD_DUTY50_EN
            m_vis  = m_clk | prev;
`else
            m_vis  = m_clk;
`endif
        end
        #1;
        chk("m_clk_out", int'(clk_out), int'(m_vis));
        chk("m_rise_stb", int'(rise_stb), int'(m_rise));
        chk("m_div_ack", int'(div_ack), int'(m_ack));
        chk("m_div_err", int'(div_err), int'(m_err));
        chk("m_busy", int'(busy), int'(m_pend >= 0));
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_ack();
        int t;
        t = 0;
        while (!div_ack && t < 300) begin
            step();
            t++;
        end
        chk("wait_ack_seen", int'(div_ack), 1);
    endtask

    task automatic rise_gap(output int gap);
        int t;
        t = 0;
        while (!rise_stb && t < 300) begin
            step();
            t++;
        end
        t = 0;
        do begin
            step();
            t++;
        end while (!rise_stb && t < 300);
        gap = t;
    endtask

    initial begin
        int gap, acks, first, hi;

        // Reset state
        repeat (3) step();
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(div_ack), 0);
        chk("rst_err", int'(div_err), 0);
        chk("rst_rise", int'(rise_stb), 0);

        // 1: default divide by 4 straight out of reset
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t1_clk", int'(clk_out), int'((i % 4) < 2));
            chk("t1_rise", int'(rise_stb), int'((i % 4) == 0));
        end

        // 2: load 7 at cnt=1
        step();
        div_load = 1'b1;
        div_val  = 8'd7;
        step();
        div_load = 1'b0;
        chk("t2_busy", int'(busy), 1);
        chk("t2_no_ack", int'(div_ack), 0);
        step();
        step();
        chk("t2_ack", int'(div_ack), 1);
        chk("t2_busy_drop", int'(busy), 0);
`ifdef CLK_DIV_ODD_DUTY50_EN
        hi = 4;
`else
        hi = 3;
`endif
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            chk("t2_clk", int'(clk_out), int'(i < hi));
        end
        step();
        chk("t2_rise", int'(rise_stb), 1);

        // 3: loads 5 then 9, last one wins
        div_load = 1'b1;
        div_val  = 8'd5;
        step();
        div_val  = 8'd9;
        step();
        div_load = 1'b0;
        chk("t3_busy", int'(busy), 1);
        acks  = 0;
        first = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (div_ack) begin
                acks++;
                if (first < 0) first = i;
            end
        end
        chk("t3_ack_at", first, 4);
        chk("t3_acks", acks, 1);
        rise_gap(gap);
        chk("t3_period", gap, 9);

        // 4: illegal divisors
        div_load = 1'b1;
        div_val  = 8'd1;
        step();
        div_load = 1'b0;
        chk("t4_err1", int'(div_err), 1);
        chk("t4_busy1", int'(busy), 0);
        div_load = 1'b1;
        div_val  = 8'd0;
        step();
        div_load = 1'b0;
        chk("t4_err0", int'(div_err), 1);
        chk("t4_busy0", int'(busy), 0);
        step();
        chk("t4_err_clr", int'(div_err), 0);
        rise_gap(gap);
        chk("t4_period", gap, 9);

        // 5: stop at cnt=1 with N=6, then restart
        div_load = 1'b1;
        div_val  = 8'd6;
        step();
        div_load = 1'b0;
        wait_ack();
        step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_clk", int'(clk_out), int'(i == 0));
            chk("t5_rise", int'(rise_stb), 0);
        end
        enable = 1'b1;
        step();
        chk("t5_restart_clk", int'(clk_out), 1);
        chk("t5_restart_rise", int'(rise_stb), 1);

        // 6: reset during RUN with N=9 and a pending load
        div_load = 1'b1;
        div_val  = 8'd9;
        step();
        div_load = 1'b0;
        wait_ack();
        step();
        step();
        div_load = 1'b1;
        div_val  = 8'd5;
        step();
        div_load = 1'b0;
        chk("t6_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_clk", int'(clk_out), 0);
        chk("t6_rst_busy", int'(busy), 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("t6_clk", int'(clk_out), 1);
        chk("t6_rise", int'(rise_stb), 1);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (div_ack) acks++;
        end
        chk("t6_no_ack", acks, 0);
        rise_gap(gap);
        chk("t6_period", gap, 4);

        // Random traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            if ($urandom % 20 == 0) enable = ~enable;
            div_load = ($urandom % 12 == 0);
            r = $urandom % 10;
            if (r == 0) div_val = W'($urandom % 2);
            else if (r == 1) div_val = 8'd255;
            else div_val = W'($urandom_range(2, 12));
            reset = ($urandom % 600 == 0);
            step();
        end
        reset    = 1'b0;
        div_load = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
